// File: rtl/spi_mem_writer_if.sv
// spi_mem_writer_if: serial input side and memory write side of the SPI memory loader
interface spi_mem_writer_if #(
  parameter int addrWidth = 16,
  parameter int dataWidth = 8
);
  logic                 sclkPosEdge;
  logic                 csN;
  logic                 mosi;
  logic [addrWidth-1:0] memAddr;
  logic [dataWidth-1:0] memData;
  logic                 memWrEn;
  logic [addrWidth-1:0] byteCount;
  logic                 wrapped;
  modport master (
    output sclkPosEdge, csN, mosi,
    input  memAddr, memData, memWrEn, byteCount, wrapped
  );
  modport slave (
    input  sclkPosEdge, csN, mosi,
    output memAddr, memData, memWrEn, byteCount, wrapped
  );
endinterface

// File: rtl/spi_mem_writer.sv
// spi_mem_writer: deserialises MOSI words MSB first and writes each to an auto-incrementing, wrapping address
module spi_mem_writer #(
  parameter int addrWidth = 16,
  parameter int depth     = 2**addrWidth,
  parameter int dataWidth = 8
) (
  input logic             clk,
  input logic             rst_n,
  spi_mem_writer_if.slave bus
);
  localparam int CntWidth = (dataWidth > 1) ? $clog2(dataWidth) : 1;
  localparam logic [CntWidth-1:0]  LastBit  = CntWidth'(dataWidth - 1);
  localparam logic [addrWidth-1:0] LastAddr = addrWidth'(depth - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;
  state_t               state_q;
  logic [dataWidth-1:0] shift_q, mem_data_q, shifted;
  logic [CntWidth-1:0]  bit_cnt_q;
  logic [addrWidth-1:0] mem_addr_q, byte_count_q;
  logic                 mem_wr_en_q, wrapped_q, strobe, at_last;
  assign strobe  = bus.sclkPosEdge && !bus.csN;
  assign shifted = {shift_q[dataWidth-2:0], bus.mosi};
  assign at_last = mem_addr_q == LastAddr;
  assign bus.memAddr   = mem_addr_q;
  assign bus.memData   = mem_data_q;
  assign bus.memWrEn   = mem_wr_en_q;
  assign bus.byteCount = byte_count_q;
  assign bus.wrapped   = wrapped_q;
  // frame FSM: shift bits in SHIFT, emit one write strobe per word in WRITE while still catching the next bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      mem_data_q   <= '0;
      mem_addr_q   <= '0;
      mem_wr_en_q  <= 1'b0;
      byte_count_q <= '0;
      wrapped_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_wr_en_q <= 1'b0;
          bit_cnt_q   <= '0;
          shift_q     <= '0;
          if (!bus.csN) state_q <= SHIFT;
        end
        SHIFT: begin
          if (bus.csN) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end else if (bus.sclkPosEdge) begin
            shift_q <= shifted;
            if (bit_cnt_q == LastBit) begin
              mem_data_q  <= shifted;
              mem_wr_en_q <= 1'b1;
              bit_cnt_q   <= '0;
              state_q     <= WRITE;
            end else begin
              bit_cnt_q <= bit_cnt_q + CntWidth'(1);
            end
          end
        end
        WRITE: begin
          mem_wr_en_q  <= 1'b0;
          mem_addr_q   <= at_last ? '0 : mem_addr_q + addrWidth'(1);
          wrapped_q    <= wrapped_q | at_last;
          byte_count_q <= byte_count_q + addrWidth'(1);
          state_q      <= bus.csN ? IDLE : SHIFT;
          if (strobe) begin
            shift_q   <= shifted;
            bit_cnt_q <= CntWidth'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mem_writer.sv
// tb_spi_mem_writer: directed frames against a full-size writer and a depth-4 writer, with write scoreboards
module tb_spi_mem_writer;
  logic clk = 1'b0, rst_n = 1'b0, cs = 1'b1, sclk = 1'b0, mosi = 1'b0, sel = 1'b0;
  int n_vec = 0, n_err = 0;
  logic [23:0] qa[$], qb[$];
  logic [23:0] ea, eb;
  always #5 clk = ~clk;
  spi_mem_writer_if #(.addrWidth(16), .dataWidth(8)) ifa ();
  spi_mem_writer_if #(.addrWidth(2),  .dataWidth(8)) ifb ();
  assign ifa.sclkPosEdge = sclk;
  assign ifa.mosi        = mosi;
  assign ifa.csN         = sel ? 1'b1 : cs;
  assign ifb.sclkPosEdge = sclk;
  assign ifb.mosi        = mosi;
  assign ifb.csN         = sel ? cs : 1'b1;
  spi_mem_writer #(.addrWidth(16), .depth(65536), .dataWidth(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  spi_mem_writer #(.addrWidth(2),  .depth(4),     .dataWidth(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // write monitors: every memWrEn cycle must match the oldest expected {addr,data}
  always @(negedge clk) begin
    if (rst_n && ifa.memWrEn) begin
      if (qa.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL write_a: got addr=0x%0h data=0x%0h, expected no write", ifa.memAddr, ifa.memData);
      end else begin
        ea = qa.pop_front();
        chk("write_a", 32'({ifa.memAddr, ifa.memData}), 32'(ea));
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n && ifb.memWrEn) begin
      if (qb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL write_b: got addr=0x%0h data=0x%0h, expected no write", ifb.memAddr, ifb.memData);
      end else begin
        eb = qb.pop_front();
        chk("write_b", 32'({14'd0, ifb.memAddr, ifb.memData}), 32'(eb));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int addr, input logic [7:0] data);
    if (sel) qb.push_back({addr[15:0], data});
    else     qa.push_back({addr[15:0], data});
  endtask

  task automatic strobe(input logic b, input bit gap, input bit last);
    mosi = b;
    sclk = 1'b1;
    tick();
    if (last) chk("latency", 32'(sel ? ifb.memWrEn : ifa.memWrEn), 32'd1);
    if (gap) begin
      sclk = 1'b0;
      mosi = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit gap);
    for (int i = 7; i >= 0; i--) strobe(d[i], gap, i == 0);
  endtask

  task automatic begin_frame();
    cs = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    sclk = 1'b0;
    cs   = 1'b1;
    tick();
  endtask

  task automatic chk_state(input string tag, input int addr, input int cnt, input int wrp);
    chk({tag, "_addr"},  32'(sel ? 16'(ifb.memAddr)   : ifa.memAddr),   32'(addr));
    chk({tag, "_count"}, 32'(sel ? 16'(ifb.byteCount) : ifa.byteCount), 32'(cnt));
    chk({tag, "_wrap"},  32'(sel ? ifb.wrapped : ifa.wrapped), 32'(wrp));
    chk({tag, "_wren"},  32'(sel ? ifb.memWrEn : ifa.memWrEn), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk_state("reset_a", 0, 0, 0);
    chk("reset_a_data", 32'(ifa.memData), 32'd0);
    sel = 1'b1;
    chk_state("reset_b", 0, 0, 0);
    sel = 1'b0;
    rst_n = 1'b1;
    tick();
    // single byte
    push(0, 8'hA5);
    begin_frame(); send_byte(8'hA5, 1'b1); end_frame();
    chk_state("single", 1, 1, 0);
    // back-to-back, divide-by-2
    push(1, 8'h3C); push(2, 8'hFF);
    begin_frame(); send_byte(8'h3C, 1'b1); send_byte(8'hFF, 1'b1); end_frame();
    chk_state("b2b", 3, 3, 0);
    // continuous strobes: next word's bit 0 lands in the WRITE cycle; csN rises during the last WRITE
    push(3, 8'h12); push(4, 8'h34);
    begin_frame(); send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0); end_frame();
    chk_state("burst", 5, 5, 0);
    // aborted frame after 5 bits, then a full word reuses the address
    begin_frame();
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1, 1'b0);
    end_frame();
    chk_state("abort", 5, 5, 0);
    push(5, 8'h81);
    begin_frame(); send_byte(8'h81, 1'b1); end_frame();
    chk_state("after_abort", 6, 6, 0);
    // csN rises together with the 8th strobe
    begin_frame();
    for (int i = 0; i < 7; i++) strobe(1'b0, 1'b1, 1'b0);
    mosi = 1'b1; sclk = 1'b1; cs = 1'b1;
    tick();
    sclk = 1'b0;
    repeat (2) tick();
    chk_state("coincident", 6, 6, 0);
    // reset mid-frame
    begin_frame();
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_state("midreset", 0, 0, 0);
    chk("midreset_data", 32'(ifa.memData), 32'd0);
    cs = 1'b1; rst_n = 1'b1;
    tick();
    push(0, 8'h5A);
    begin_frame(); send_byte(8'h5A, 1'b1); end_frame();
    chk_state("post_reset", 1, 1, 0);
    // wrap on the depth-4 instance; strobes with csN high must leave instance A untouched
    sel = 1'b1;
    push(0, 8'h01); push(1, 8'h02); push(2, 8'h03);
    begin_frame(); send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); end_frame();
    chk_state("prewrap", 3, 3, 0);
    push(3, 8'h04); push(0, 8'h05);
    begin_frame(); send_byte(8'h04, 1'b1); send_byte(8'h05, 1'b1); end_frame();
    chk_state("wrap", 1, 1, 1);
    sel = 1'b0;
    chk_state("idle_a", 1, 1, 0);
    repeat (4) tick();
    chk("pending_a", 32'(qa.size()), 32'd0);
    chk("pending_b", 32'(qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_mem_writer.md
Name: spi_mem_writer

Overview:
Receive-side counterpart of the program counter that feeds the SPI transmitter. It deserialises MOSI bits on serial-clock rising-edge strobes, MSB first, into 8-bit bytes. It then issues a one-cycle memory write per completed byte at an auto-incrementing address that wraps at the memory depth. It sits between the serialClock strobe generator and the sample memory write port, and is used to load memory over SPI.

Parameters:
addrWidth, 16, width of memAddr
depth, 2**addrWidth, number of memory words; address wraps from depth-1 to 0
dataWidth, 8, bits per word; also the number of sclk strobes per write

Ports:
clk  input  1  system clock; all logic is on its rising edge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
sclkPosEdge  input  1  one-clk-wide strobe marking an sclk rising edge (from serialClock)
csN  input  1  active-low frame select; bits are accepted only while low
mosi  input  1  serial data in, sampled when sclkPosEdge=1
memAddr  output  addrWidth  write address; valid while memWrEn=1
memData  output  dataWidth  assembled word; valid while memWrEn=1
memWrEn  output  1  one-clk write strobe per completed word
byteCount  output  addrWidth  words written since reset; wraps modulo 2**addrWidth
wrapped  output  1  sticky flag; set when memAddr wraps from depth-1 to 0

Behaviour:
- Reset (rst_n=0 at posedge clk) has priority over everything, including mid-frame and mid-write.
  - All outputs go to 0: memAddr, memData, memWrEn, byteCount, wrapped.
  - Shift register and bit counter go to 0; state goes to IDLE.
- States: IDLE, SHIFT, WRITE.
- IDLE:
  - memWrEn=0.
  - csN=0 -> SHIFT with bit counter 0.
  - A strobe in the same cycle csN is first seen low is ignored. The first bit is the next strobe.
- SHIFT:
  - On sclkPosEdge=1 with csN=0: shiftReg <= {shiftReg[dataWidth-2:0], mosi}; bitCnt <= bitCnt+1.
  - On the strobe where bitCnt==dataWidth-1:
    - memData <= the completed word, including the current mosi bit.
    - memWrEn <= 1 and bitCnt <= 0; next state WRITE.
    - Latency: memWrEn is high in the clk cycle immediately after the 8th strobe's cycle.
  - csN=1 in any cycle -> IDLE.
    - The partial word is discarded and bitCnt cleared. No write occurs.
    - memAddr and byteCount are unchanged.
  - csN=1 in the same cycle as the 8th strobe: the strobe is ignored and the word is discarded.
- WRITE (exactly one clk):
  - memWrEn=1; memAddr holds the address being written.
  - On leaving WRITE, memWrEn <= 0.
  - memAddr increments, or wraps to 0 if it equals depth-1, in which case wrapped <= 1.
  - byteCount <= byteCount+1.
  - Next state: SHIFT if csN=0, else IDLE.
  - A write in progress always completes, even if csN rises during WRITE.
  - A strobe with csN=0 during WRITE is accepted as bit 0 of the next word, so back-to-back words lose no bits.
- Addressing:
  - memAddr persists across frames; successive frames append. Only rst_n returns it to 0.
  - memAddr never exceeds depth-1, even when depth < 2**addrWidth.
- memData holds its last value while memWrEn=0.
- wrapped stays set until reset.
- sclkPosEdge while csN=1 has no effect in any state.
- mosi is don't-care except in cycles with sclkPosEdge=1 and csN=0.

Test Plan:
- Reset mid-frame: rst_n=0 after 5 bits -> next cycle all outputs 0 and state IDLE. A following full frame writes at address 0 with a correct 8-bit word.
- Single byte: csN low, 8 strobes, MOSI 1,0,1,0,0,1,0,1 -> exactly one memWrEn pulse one clk after the 8th strobe with memData=0xA5, memAddr=0. Afterwards memAddr=1, byteCount=1.
- Back-to-back bytes, serialClock divide-by-2, MOSI 0x3C then 0xFF -> two one-clk pulses at addresses 0 and 1 with data 0x3C and 0xFF. No dropped bit.
- Aborted frame: csN rises after 5 strobes, then a new frame sends 0x81 -> single write of 0x81 at the address the aborted frame would have used.
- csN rising coincident with the 8th strobe -> no write; memAddr and byteCount unchanged.
- Wrap with depth=4, addrWidth=2: five bytes 0x01..0x05 -> writes at addresses 0,1,2,3,0. wrapped goes to 1 after the 4th write. byteCount ends at 1, i.e. 5 mod 4.
